decode_imm_stage: RTL and testbench
===================================

Name: decode_imm_stage

Overview:
- Registered A64 decode/immediate-extension pipeline stage for the CPU front end.
- Accepts 32-bit instruction words over a valid/ready handshake and classifies format.
- Produces the DATA_W-wide extended immediate plus a 4-bit ALU op.
- Buffers results in a small FIFO, so the fetch→decode boundary sustains one instruction per cycle under backpressure.

Parameters:
- DATA_W, 64, immediate/datapath width; legal values 32 or 64.
- DEPTH, 2, output buffer entries; power of two, ≥2.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush (branch redirect).
- in_valid  input  1  instruction word valid.
- in_ready  output  1  stage can accept a word this cycle.
- in_inst  input  32  A64 instruction word.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry.
- out_imm  output  DATA_W  extended immediate.
- out_alu_op  output  4  ALU control code.
- out_fmt  output  3  format: 0 NONE, 1 MOVZ, 2 CBZ, 3 SUBI, 4 CMP, 5 B, 6 LDST.
- out_illegal  output  1  unrecognised or width-illegal encoding.
- out_inst  output  32  original word, passed through.
- stat_decoded  output  32  accepted-instruction count (optional feature).
- stat_illegal  output  32  illegal-instruction count (optional feature).

Behaviour:
- Decode (combinational on in_inst, captured into the FIFO on accept):
  - MOVZ: inst[31:23]=110100101. imm = zext(inst[20:5]) << (16*inst[22:21]). alu_op 0001.
  - CBZ: inst[31:24]=10110100. imm = sext(inst[23:5]) << 2. alu_op 0111.
  - SUBI: inst[31:23]=110100010. imm = zext(inst[21:10]) << (inst[22]?12:0). alu_op 0010.
  - CMP (SUBS, shifted register): inst[31:24]=11101011. imm = zext(inst[15:10]) (shift amount). alu_op 0011.
  - B: inst[31:26]=000101. imm = sext(inst[25:0]) << 2. alu_op 1000.
  - LDUR: inst[31:21]=11111000010. STUR: inst[31:21]=11111000000. Both: imm = sext(inst[20:12]). alu_op 0000.
  - Otherwise: fmt NONE, imm 0, alu_op 0000, illegal=1.
- Width rules:
  - All shifts and sign extension are performed at DATA_W; bits shifted out above DATA_W are discarded.
  - DATA_W=32 and MOVZ with inst[22]=1 (hw ≥ 2) → illegal=1, imm 0.
- Handshake:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count < DEPTH) || pop. Same-cycle pop-and-push is allowed when full.
  - Latency: a word accepted in cycle N appears at the outputs in cycle N+1 if the FIFO was empty.
  - Output fields are stable while out_valid && !out_ready.
- FIFO: circular, rd/wr pointers of log2(DEPTH) bits that wrap modulo DEPTH, count of log2(DEPTH)+1 bits.
- Flush: empties the FIFO next cycle (count=0, pointers=0). A word presented in the flush cycle is dropped. A pop in the flush cycle is still considered taken by the consumer.
- Reset (asynchronous, any time including mid-transfer):
  - count/pointers 0, out_valid 0, stats 0.
  - in_ready is 1 after reset deasserts.
  - Data outputs are 0 while empty.

Optional Feature:
- DECODE_STATS_EN defined: stat_decoded increments on every accept; stat_illegal increments on accepts with illegal=1. Both counters are 32-bit and wrap; flush does not clear them.
- DECODE_STATS_EN undefined: both stat ports are tied to 0 and no counter flops are built.

Decomposition:
- Package decode_pkg:
  - fmt_e enum.
  - alu_op constants: ALU_ADD=0000, ALU_MOVZ=0001, ALU_SUB=0010, ALU_SUBS=0011, ALU_CBZ=0111, ALU_BR=1000.
  - Opcode match constants.
  - Decoded-entry struct {imm, alu_op, fmt, illegal, inst}.
- Sub-module imm_extract: purely combinational decoder, parameterised by DATA_W. The stage wraps it with the FIFO and handshake.

Test Plan:
- MOVZ 0xD2A00020 (hw=1, imm16=1), DATA_W=64 → imm 0x10000, alu_op 0001, fmt 1, one cycle after accept. MOVZ with hw=2 (inst[22:21]=10) at DATA_W=32 → illegal=1, imm 0.
- CBZ with imm19 = all ones → imm = −4 (0xFFFF_FFFF_FFFF_FFFC), fmt 2. B with imm26 = 1 → imm 4, alu_op 1000.
- SUBI imm12=0xABC, sh=1 → imm 0xABC000, alu_op 0010. LDUR imm9=0x1FF → imm −1.
- Backpressure, DEPTH=2: push 3 words with out_ready=0 → in_ready drops after the 2nd. Then hold out_ready=1 with in_valid=1 → one transfer per cycle, outputs in order, no loss.
- Flush while holding 2 entries, with a valid input that cycle → next cycle out_valid=0, count 0, dropped word never emitted.
- Assert rst_n low mid-stream → out_valid=0 immediately (asynchronous). With DECODE_STATS_EN, after 5 accepts including 1 unknown word 0x00000000: stat_decoded=5, stat_illegal=1.

Source files
------------

// File: rtl/decode_imm_stage_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg
// Shared types and constants for the A64 decode/immediate-extension stage:
//   - fmt_e       : instruction format classification (3-bit code)
//   - ALU_*       : 4-bit ALU control codes
//   - OPC_*       : fixed opcode fields matched against the top instruction bits
//   - dec_entry_t : one decoded FIFO entry {imm, alu_op, fmt, illegal, inst}
// The entry stores the immediate at the widest legal datapath width; narrower
// builds zero-pad the upper bits and only the low DATA_W bits are ever read.
// ----------------------------------------------------------------------------
package decode_pkg;

    localparam int IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_MOVZ = 3'd1,
        FMT_CBZ  = 3'd2,
        FMT_SUBI = 3'd3,
        FMT_CMP  = 3'd4,
        FMT_B    = 3'd5,
        FMT_LDST = 3'd6
    } fmt_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_MOVZ = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SUBS = 4'b0011;
    localparam logic [3:0] ALU_CBZ  = 4'b0111;
    localparam logic [3:0] ALU_BR   = 4'b1000;

    localparam logic [8:0]  OPC_MOVZ = 9'b110100101;     // inst[31:23]
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;      // inst[31:24]
    localparam logic [8:0]  OPC_SUBI = 9'b110100010;     // inst[31:23]
    localparam logic [7:0]  OPC_CMP  = 8'b11101011;      // inst[31:24]
    localparam logic [5:0]  OPC_B    = 6'b000101;        // inst[31:26]
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;  // inst[31:21]
    localparam logic [10:0] OPC_STUR = 11'b11111000000;  // inst[31:21]

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        logic [3:0]           alu_op;
        fmt_e                 fmt;
        logic                 illegal;
        logic [31:0]          inst;
    } dec_entry_t;

endpackage

// File: rtl/decode_imm_stage_if.sv
// ----------------------------------------------------------------------------
// decode_imm_stage_if
// Fetch-side input handshake plus decode-side output handshake of the stage.
//   in_valid/in_ready/in_inst           : instruction word from fetch
//   out_valid/out_ready                 : head-of-FIFO handshake to consumer
//   out_imm/out_alu_op/out_fmt/
//   out_illegal/out_inst                : decoded head entry
// Modports: slave = the decode stage, master = its environment.
// ----------------------------------------------------------------------------
interface decode_imm_stage_if #(
    parameter int DATA_W = 64
);
    import decode_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic [3:0]        out_alu_op;
    fmt_e              out_fmt;
    logic              out_illegal;
    logic [31:0]       out_inst;

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_imm, out_alu_op, out_fmt, out_illegal, out_inst
    );

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_imm, out_alu_op, out_fmt, out_illegal, out_inst
    );

endinterface

// File: rtl/decode_imm_stage_imm_extract.sv
// ----------------------------------------------------------------------------
// imm_extract
// Purely combinational A64 format classifier and immediate extender.
//   i_inst    : 32-bit instruction word
//   o_imm     : DATA_W-wide extended immediate (0 when illegal)
//   o_alu_op  : 4-bit ALU control code
//   o_fmt     : format classification
//   o_illegal : unrecognised encoding, or MOVZ half-word shift beyond DATA_W
// All shifts and sign extensions happen at DATA_W; bits above are discarded.
// A width-illegal MOVZ keeps its MOVZ format/op so the consumer can tell it
// apart from an unrecognised word.
// ----------------------------------------------------------------------------
module imm_extract
    import decode_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [31:0]       i_inst,
    output logic [DATA_W-1:0] o_imm,
    output logic [3:0]        o_alu_op,
    output fmt_e              o_fmt,
    output logic              o_illegal
);

    always_comb begin
        // NOTE: every output gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        o_imm     = '0;
        o_alu_op  = ALU_ADD;
        o_fmt     = FMT_NONE;
        o_illegal = 1'b0;

        if (i_inst[31:23] == OPC_MOVZ) begin
            o_fmt    = FMT_MOVZ;
            o_alu_op = ALU_MOVZ;
            // hw >= 2 would shift the half-word entirely out of a 32-bit datapath
            if (DATA_W == 32 && i_inst[22]) begin
                o_illegal = 1'b1;
            end else begin
                o_imm = DATA_W'(i_inst[20:5]) << {i_inst[22:21], 4'b0000};
            end
        end else if (i_inst[31:24] == OPC_CBZ) begin
            o_fmt    = FMT_CBZ;
            o_alu_op = ALU_CBZ;
            o_imm    = {{(DATA_W-19){i_inst[23]}}, i_inst[23:5]} << 2;
        end else if (i_inst[31:23] == OPC_SUBI) begin
            o_fmt    = FMT_SUBI;
            o_alu_op = ALU_SUB;
            o_imm    = DATA_W'(i_inst[21:10]) << (i_inst[22] ? 4'd12 : 4'd0);
        end else if (i_inst[31:24] == OPC_CMP) begin
            o_fmt    = FMT_CMP;
            o_alu_op = ALU_SUBS;
            o_imm    = DATA_W'(i_inst[15:10]);
        end else if (i_inst[31:26] == OPC_B) begin
            o_fmt    = FMT_B;
            o_alu_op = ALU_BR;
            o_imm    = {{(DATA_W-26){i_inst[25]}}, i_inst[25:0]} << 2;
        end else if (i_inst[31:21] == OPC_LDUR || i_inst[31:21] == OPC_STUR) begin
            o_fmt    = FMT_LDST;
            o_alu_op = ALU_ADD;
            o_imm    = {{(DATA_W-9){i_inst[20]}}, i_inst[20:12]};
        end else begin
            o_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_imm_stage.sv
// ----------------------------------------------------------------------------
// decode_imm_stage
// Registered A64 decode/immediate-extension stage. Words accepted on the input
// handshake are decoded by imm_extract and written into a DEPTH-entry circular
// FIFO; the head entry drives the outputs (all zero while empty).
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : synchronous flush; empties the FIFO, drops the input word
//   bus (slave)    : in_valid/in_ready/in_inst, out_valid/out_ready + fields
//   stat_decoded   : accepted-word counter (0 unless DECODE_STATS_EN)
//   stat_illegal   : accepted-illegal-word counter (0 unless DECODE_STATS_EN)
// Optional feature macro: DECODE_STATS_EN builds the two 32-bit wrapping
// counters; flush does not clear them.
// ----------------------------------------------------------------------------
module decode_imm_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    decode_imm_stage_if.slave bus,
    output logic [31:0]       stat_decoded,
    output logic [31:0]       stat_illegal
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] w_imm;
    logic [3:0]        w_alu_op;
    fmt_e              w_fmt;
    logic              w_illegal;
    dec_entry_t        w_entry;
    dec_entry_t        w_head;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;

    dec_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    imm_extract #(.DATA_W(DATA_W)) u_imm_extract (
        .i_inst    (bus.in_inst),
        .o_imm     (w_imm),
        .o_alu_op  (w_alu_op),
        .o_fmt     (w_fmt),
        .o_illegal (w_illegal)
    );

    assign w_entry = '{imm: IMM_MAX_W'(w_imm), alu_op: w_alu_op, fmt: w_fmt,
                       illegal: w_illegal, inst: bus.in_inst};

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign w_out_valid  = (r_count != '0);
    assign w_pop        = w_out_valid && bus.out_ready;
    assign bus.in_ready = (r_count < CNT_FULL) || w_pop;
    assign w_push       = bus.in_valid && bus.in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state uses non-blocking assignments so every flop samples
            // pre-edge values regardless of statement order.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the entry storage is not reset; r_count gates every read, so stale
    // contents are never visible and the array stays plain RAM/flops.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign bus.out_valid   = w_out_valid;
    assign bus.out_imm     = w_out_valid ? w_head.imm[DATA_W-1:0] : '0;
    assign bus.out_alu_op  = w_out_valid ? w_head.alu_op : ALU_ADD;
    assign bus.out_fmt     = w_out_valid ? w_head.fmt : FMT_NONE;
    assign bus.out_illegal = w_out_valid ? w_head.illegal : 1'b0;
    assign bus.out_inst    = w_out_valid ? w_head.inst : 32'd0;

`ifdef DECODE_STATS_EN
    logic [31:0] r_stat_decoded;
    logic [31:0] r_stat_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_decoded <= '0;
            r_stat_illegal <= '0;
        end else if (w_push) begin
            r_stat_decoded <= r_stat_decoded + 32'd1;
            if (w_entry.illegal) r_stat_illegal <= r_stat_illegal + 32'd1;
        end
    end

    assign stat_decoded = r_stat_decoded;
    assign stat_illegal = r_stat_illegal;
`else
    assign stat_decoded = '0;
    assign stat_illegal = '0;
`endif

endmodule

// File: tb/tb_decode_imm_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_imm_stage
// Scoreboard bench for decode_imm_stage. Two instances: DATA_W=64/DEPTH=2 and
// DATA_W=32/DEPTH=4. An input tracker pushes the reference-model result of
// every accepted word; an output monitor pops and compares on every transfer
// and checks that data outputs are zero while empty.
// ----------------------------------------------------------------------------
module tb_decode_imm_stage;

    typedef struct packed {
        logic [63:0] imm;
        logic [3:0]  op;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] inst;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
    logic flush32;
    logic [31:0] stat_dec, stat_ill, stat_dec32, stat_ill32;

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;
    int ill_cnt  = 0;

    exp_t q64[$];
    exp_t q32[$];
    exp_t mon64_e, mon32_e, trk64_e, trk32_e;

    decode_imm_stage_if #(.DATA_W(64)) bus64 ();
    decode_imm_stage_if #(.DATA_W(32)) bus32 ();

    decode_imm_stage #(.DATA_W(64), .DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64.slave),
        .stat_decoded(stat_dec), .stat_illegal(stat_ill)
    );

    decode_imm_stage #(.DATA_W(32), .DEPTH(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32), .bus(bus32.slave),
        .stat_decoded(stat_dec32), .stat_illegal(stat_ill32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (specification arithmetic) ------------
    function automatic exp_t model(input logic [31:0] i, input int w);
        exp_t   e;
        longint v;
        v      = 0;
        e.inst = i;
        e.op   = 4'd0;
        e.fmt  = 3'd0;
        e.ill  = 1'b0;
        if (i[31:23] == 9'b110100101) begin
            e.fmt = 3'd1; e.op = 4'b0001;
            if (w == 32 && int'(i[22:21]) >= 2) e.ill = 1'b1;
            else v = longint'(i[20:5]) * (longint'(1) << (16 * int'(i[22:21])));
        end else if (i[31:24] == 8'b10110100) begin
            e.fmt = 3'd2; e.op = 4'b0111;
            v = longint'($signed(i[23:5])) * 4;
        end else if (i[31:23] == 9'b110100010) begin
            e.fmt = 3'd3; e.op = 4'b0010;
            v = longint'(i[21:10]) * (i[22] ? 4096 : 1);
        end else if (i[31:24] == 8'b11101011) begin
            e.fmt = 3'd4; e.op = 4'b0011;
            v = longint'(i[15:10]);
        end else if (i[31:26] == 6'b000101) begin
            e.fmt = 3'd5; e.op = 4'b1000;
            v = longint'($signed(i[25:0])) * 4;
        end else if (i[31:21] == 11'b11111000010 || i[31:21] == 11'b11111000000) begin
            e.fmt = 3'd6; e.op = 4'b0000;
            v = longint'($signed(i[20:12]));
        end else begin
            e.ill = 1'b1;
        end
        e.imm = (w == 32) ? {32'd0, v[31:0]} : v;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r[31:23] = 9'b110100101;
            1: r[31:24] = 8'b10110100;
            2: r[31:23] = 9'b110100010;
            3: r[31:24] = 8'b11101011;
            4: r[31:26] = 6'b000101;
            5: r[31:21] = 11'b11111000010;
            6: r[31:21] = 11'b11111000000;
            default: ;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_entry(input string tag, input exp_t e, input logic [63:0] imm,
                             input logic [3:0] op, input logic [2:0] fmt, input logic ill,
                             input logic [31:0] inst);
        check({tag, "_inst"}, inst, e.inst);
        check({tag, "_imm"},  imm,  e.imm);
        check({tag, "_op"},   op,   e.op);
        check({tag, "_fmt"},  fmt,  e.fmt);
        check({tag, "_ill"},  ill,  e.ill);
    endtask

    // ---------------- scoreboard: input trackers ----------------------------
    always @(negedge rst_n) begin
        q64.delete();
        q32.delete();
        acc_cnt = 0;
        ill_cnt = 0;
    end

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (flush) q64.delete();
            else if (bus64.in_valid && bus64.in_ready) begin
                trk64_e = model(bus64.in_inst, 64);
                q64.push_back(trk64_e);
                acc_cnt++;
                if (trk64_e.ill) ill_cnt++;
            end
            if (flush32) q32.delete();
            else if (bus32.in_valid && bus32.in_ready) begin
                trk32_e = model(bus32.in_inst, 32);
                q32.push_back(trk32_e);
            end
        end
    end

    // ---------------- scoreboard: output monitors ---------------------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus64.out_valid && bus64.out_ready) begin
                if (q64.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL mon64_unexpected: got inst 0x%0h expected no output", bus64.out_inst);
                end else begin
                    mon64_e = q64.pop_front();
                    cmp_entry("mon64", mon64_e, bus64.out_imm, bus64.out_alu_op, bus64.out_fmt,
                              bus64.out_illegal, bus64.out_inst);
                end
            end else if (!bus64.out_valid) begin
                check("idle64_imm", bus64.out_imm, 64'd0);
                check("idle64_inst", {32'd0, bus64.out_inst}, 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus32.out_valid && bus32.out_ready) begin
                if (q32.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL mon32_unexpected: got inst 0x%0h expected no output", bus32.out_inst);
                end else begin
                    mon32_e = q32.pop_front();
                    cmp_entry("mon32", mon32_e, {32'd0, bus32.out_imm}, bus32.out_alu_op,
                              bus32.out_fmt, bus32.out_illegal, bus32.out_inst);
                end
            end else if (!bus32.out_valid) begin
                check("idle32_imm", {32'd0, bus32.out_imm}, 64'd0);
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic send64(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        bus64.in_valid = 1'b1;
        bus64.in_inst  = w;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk); #2;
            if (bus64.in_ready) ok = 1'b1;
        end
        check("send64_accepted", {63'd0, ok}, 64'd1);
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        bus32.in_valid = 1'b1;
        bus32.in_inst  = w;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk); #2;
            if (bus32.in_ready) ok = 1'b1;
        end
        check("send32_accepted", {63'd0, ok}, 64'd1);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
    endtask

    task automatic pop64();
        bus64.out_ready = 1'b1;
        @(posedge clk); #1;
        bus64.out_ready = 1'b0;
    endtask

    task automatic expect_head64(input string tag, input logic [63:0] imm, input logic [3:0] op,
                                 input logic [2:0] fmt, input logic ill);
        check({tag, "_valid"}, {63'd0, bus64.out_valid}, 64'd1);
        check({tag, "_imm"}, bus64.out_imm, imm);
        check({tag, "_op"}, {60'd0, bus64.out_alu_op}, {60'd0, op});
        check({tag, "_fmt"}, {61'd0, bus64.out_fmt}, {61'd0, fmt});
        check({tag, "_ill"}, {63'd0, bus64.out_illegal}, {63'd0, ill});
    endtask

    task automatic drain();
        bus64.in_valid  = 1'b0;
        bus32.in_valid  = 1'b0;
        bus64.out_ready = 1'b1;
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 40 && (q64.size() != 0 || q32.size() != 0); i++) @(posedge clk);
        @(posedge clk); #1;
        check("drain_q64_empty", 64'(q64.size()), 64'd0);
        check("drain_q32_empty", 64'(q32.size()), 64'd0);
    endtask

    // ---------------- main sequence -----------------------------------------
    initial begin
        rst_n = 1'b0; flush = 1'b0; flush32 = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_inst = '0; bus64.out_ready = 1'b0;
        bus32.in_valid = 1'b0; bus32.in_inst = '0; bus32.out_ready = 1'b1;
        #12;
        check("rst_out_valid", {63'd0, bus64.out_valid}, 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", {63'd0, bus64.in_ready}, 64'd1);
        check("rst_out_imm", bus64.out_imm, 64'd0);
        check("rst_stat_decoded", {32'd0, stat_dec}, 64'd0);

        // Directed decodes at DATA_W=64, checked one cycle after accept.
        send64(32'hD2A00020); expect_head64("movz_hw1", 64'h10000, 4'b0001, 3'd1, 1'b0); pop64();
        send64(32'hB4FFFFE0); expect_head64("cbz_neg", 64'hFFFF_FFFF_FFFF_FFFC, 4'b0111, 3'd2, 1'b0); pop64();
        send64(32'h14000001); expect_head64("b_plus1", 64'd4, 4'b1000, 3'd5, 1'b0); pop64();
        send64(32'hD16AF000); expect_head64("subi_sh", 64'hABC000, 4'b0010, 3'd3, 1'b0); pop64();
        send64(32'hF85FF000); expect_head64("ldur_m1", 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 3'd6, 1'b0); pop64();
        send64(32'h00000000); expect_head64("unknown", 64'd0, 4'b0000, 3'd0, 1'b1); pop64();

        // DATA_W=32 instance: width-illegal MOVZ and truncation.
        send32(32'hD2C00020);
        check("movz32_hw2_ill", {63'd0, bus32.out_illegal}, 64'd1);
        check("movz32_hw2_imm", {32'd0, bus32.out_imm}, 64'd0);
        send32(32'hB4FFFFE0);
        check("cbz32_imm", {32'd0, bus32.out_imm}, 64'hFFFF_FFFC);
        for (int c = 0; c < 200; c++) begin
            bus32.in_valid  = ($urandom_range(0, 3) != 0);
            bus32.in_inst   = rand_inst();
            bus32.out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        drain();
        bus64.out_ready = 1'b0;

        // Backpressure: two entries fill DEPTH=2, the third word stalls.
        send64(rand_inst());
        send64(rand_inst());
        bus64.in_valid = 1'b1;
        bus64.in_inst  = rand_inst();
        @(negedge clk); #2;
        check("bp_full_in_ready", {63'd0, bus64.in_ready}, 64'd0);
        @(posedge clk); #1;
        bus64.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #2;
            check("bp_stream_in_ready", {63'd0, bus64.in_ready}, 64'd1);
            check("bp_stream_out_valid", {63'd0, bus64.out_valid}, 64'd1);
            @(posedge clk); #1;
            bus64.in_inst = rand_inst();
        end
        drain();

        // Flush with two entries held and a word presented in the flush cycle.
        bus64.out_ready = 1'b0;
        send64(rand_inst());
        send64(rand_inst());
        flush = 1'b1;
        bus64.in_valid  = 1'b1;
        bus64.in_inst   = 32'h14000123;
        bus64.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        flush = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.out_ready = 1'b0;
        check("flush_out_valid", {63'd0, bus64.out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, bus64.in_ready}, 64'd1);
        bus64.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Randomised traffic with occasional flushes.
        for (int c = 0; c < 800; c++) begin
            bus64.in_valid  = ($urandom_range(0, 3) != 0);
            bus64.in_inst   = rand_inst();
            bus64.out_ready = ($urandom_range(0, 3) != 0);
            flush           = ($urandom_range(0, 49) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        drain();
`ifdef DECODE_STATS_EN
        check("stat_decoded_run", {32'd0, stat_dec}, 64'(acc_cnt));
        check("stat_illegal_run", {32'd0, stat_ill}, 64'(ill_cnt));
`else
        check("stat_decoded_off", {32'd0, stat_dec}, 64'd0);
        check("stat_illegal_off", {32'd0, stat_ill}, 64'd0);
`endif

        // Asynchronous reset in the middle of a cycle with entries held.
        bus64.out_ready = 1'b0;
        send64(rand_inst());
        send64(rand_inst());
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {63'd0, bus64.out_valid}, 64'd0);
        check("async_rst_out_imm", bus64.out_imm, 64'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", {63'd0, bus64.in_ready}, 64'd1);

        // Five accepts after reset, one of them unrecognised.
        bus64.out_ready = 1'b1;
        send64(32'hD2A00020);
        send64(32'h14000001);
        send64(32'hD16AF000);
        send64(32'hF85FF000);
        send64(32'h00000000);
        drain();
`ifdef DECODE_STATS_EN
        check("stat_decoded_5", {32'd0, stat_dec}, 64'd5);
        check("stat_illegal_1", {32'd0, stat_ill}, 64'd1);
`else
        check("stat_decoded_tied", {32'd0, stat_dec}, 64'd0);
        check("stat_illegal_tied", {32'd0, stat_ill}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
